// File: rtl/m68k_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : m68k_bus_pkg
//  Purpose  : Shared types and constants for the 68000 bus controller.
//  Revision : 1.0  initial release
// ============================================================================
package m68k_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_BERR = 2'd3
  } bus_state_t;

  localparam logic [2:0] FC_IACK = 3'b111;
  localparam int         WAIT_W  = 4;

endpackage
`default_nettype wire

// File: rtl/m68k_ipl_enc.sv
`default_nettype none
// ============================================================================
//  Module   : m68k_ipl_enc
//  Purpose  : Seven-line interrupt priority encoder with registered IPLn.
//  Revision : 1.0  initial release
// ============================================================================
module m68k_ipl_enc (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] irq,
  output logic [2:0] ipl_n
);

  logic [2:0] w_level;
  logic [2:0] r_ipl_n;

  // Highest set line wins: later iterations override lower levels.
  always_comb begin
    w_level = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (irq[k]) w_level = 3'(k + 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ipl_n <= 3'b111;
    else       r_ipl_n <= ~w_level;
  end

  assign ipl_n = r_ipl_n;

endmodule
`default_nettype wire

// File: rtl/m68k_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : m68k_bus_ctrl
//  Purpose  : 68000 bus controller: region decode, wait states, DTACK/VPA/
//             BERR generation and IPL encoding. Optional bus-error support
//             is enabled with the M68K_BUS_BERR_EN macro.
//  Revision : 1.0  initial release
// ============================================================================
module m68k_bus_ctrl
  import m68k_bus_pkg::*;
#(
  parameter int                          N_REGIONS    = 8,
  parameter int                          REGION_LSB   = 15,
  parameter int                          REGION_BITS  = 3,
  parameter logic [4*N_REGIONS-1:0]      WAIT_STATES  = '0,
  parameter int                          TIMEOUT      = 255,
  parameter int                          TIMEOUT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 as_n,
  input  logic                 rw,
  input  logic [2:0]           fc,
  input  logic [23:1]          addr,
  input  logic [N_REGIONS-1:0] ext_rdy,
  input  logic [6:0]           irq,
  output logic [N_REGIONS-1:0] sel,
  output logic                 dtack_n,
  output logic                 vpa_n,
  output logic                 berr_n,
  output logic [2:0]           ipl_n,
  output logic [2:0]           iack_level
);

  bus_state_t             r_state, w_state_nxt;
  logic [N_REGIONS-1:0]   r_sel, w_sel_dec;
  logic [WAIT_W-1:0]      r_wait, w_ws_dec;
  logic                   r_iack;
  logic [2:0]             r_iack_level;
  logic [REGION_BITS-1:0] w_idx;
  logic                   w_mapped, w_rdy, w_is_iack, w_timeout;

  assign w_idx     = addr[REGION_LSB+REGION_BITS-1:REGION_LSB];
  assign w_is_iack = (fc == FC_IACK);
  // sel is one-hot, so masking avoids indexing ext_rdy by region number.
  assign w_rdy     = |(ext_rdy & r_sel);

  always_comb begin
    w_sel_dec = '0;
    w_ws_dec  = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (w_idx == i[REGION_BITS-1:0]) begin
        w_sel_dec[i] = 1'b1;
        w_ws_dec     = WAIT_STATES[i*WAIT_W +: WAIT_W];
      end
    end
  end
  assign w_mapped = |w_sel_dec;

`ifdef M68K_BUS_BERR_EN
  localparam bus_state_t            c_unmapped_state = ST_BERR;
  localparam logic [TIMEOUT_BITS-1:0] c_timeout      = TIMEOUT_BITS'(TIMEOUT);
  logic [TIMEOUT_BITS-1:0] r_tmo, w_tmo_inc;

  assign w_tmo_inc = r_tmo + 1'b1;
  // Fires on the step that would bring the count to TIMEOUT.
  assign w_timeout = (w_tmo_inc == c_timeout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (ce) begin
      if (r_state == ST_IDLE)      r_tmo <= '0;
      else if (r_state == ST_WAIT) r_tmo <= w_tmo_inc;
    end
  end
`else
  localparam bus_state_t c_unmapped_state = ST_ACK;
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT < (1 << TIMEOUT_BITS));
  assign w_timeout    = 1'b0;
`endif

  logic w_unused;
  assign w_unused = &{1'b0, rw, addr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   r_state <= ST_IDLE;
    else if (ce) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!as_n) begin
          if (w_is_iack)     w_state_nxt = ST_ACK;
          else if (w_mapped) w_state_nxt = ST_WAIT;
          else               w_state_nxt = c_unmapped_state;
        end
      end
      ST_WAIT: begin
        if (as_n)                             w_state_nxt = ST_IDLE;
        else if ((r_wait == '0) && w_rdy)     w_state_nxt = ST_ACK;
        else if (w_timeout)                   w_state_nxt = ST_BERR;
      end
      ST_ACK, ST_BERR: begin
        if (as_n) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel        <= '0;
      r_wait       <= '0;
      r_iack       <= 1'b0;
      r_iack_level <= 3'd0;
    end else if (ce) begin
      if (r_state == ST_IDLE && !as_n) begin
        r_iack <= w_is_iack;
        if (w_is_iack) begin
          r_iack_level <= addr[3:1];
        end else begin
          r_sel  <= w_sel_dec;
          r_wait <= w_ws_dec;
        end
      end else if (r_state == ST_WAIT && r_wait != '0) begin
        r_wait <= r_wait - 1'b1;
      end
      if (w_state_nxt == ST_IDLE) r_sel <= '0;
    end
  end

  always_comb begin
    dtack_n = 1'b1;
    vpa_n   = 1'b1;
    berr_n  = 1'b1;
    if (r_state == ST_ACK) begin
      if (r_iack) vpa_n   = 1'b0;
      else        dtack_n = 1'b0;
    end
`ifdef M68K_BUS_BERR_EN
    if (r_state == ST_BERR) berr_n = 1'b0;
`endif
  end

  assign sel        = r_sel;
  assign iack_level = r_iack_level;

  m68k_ipl_enc u_ipl_enc (
    .clk   (clk),
    .reset (reset),
    .irq   (irq),
    .ipl_n (ipl_n)
  );

endmodule
`default_nettype wire

// File: tb/tb_m68k_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m68k_bus_ctrl
//  Purpose  : Directed self-checking bench for m68k_bus_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_m68k_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       as_n = 1'b1;
  logic       rw = 1'b1;
  logic [2:0] fc = 3'b101;
  logic [23:1] addr = '0;
  logic [7:0] ext_rdy = 8'hFF;
  logic [6:0] irq = 7'd0;
  logic [7:0] sel;
  logic       dtack_n, vpa_n, berr_n;
  logic [2:0] ipl_n, iack_level;

  int n_total = 0;
  int n_pass  = 0;

  m68k_bus_ctrl #(
    .N_REGIONS    (8),
    .REGION_LSB   (15),
    .REGION_BITS  (3),
    .WAIT_STATES  (32'h0000_2000),
    .TIMEOUT      (15),
    .TIMEOUT_BITS (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .as_n       (as_n),
    .rw         (rw),
    .fc         (fc),
    .addr       (addr),
    .ext_rdy    (ext_rdy),
    .irq        (irq),
    .sel        (sel),
    .dtack_n    (dtack_n),
    .vpa_n      (vpa_n),
    .berr_n     (berr_n),
    .ipl_n      (ipl_n),
    .iack_level (iack_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One Phi1 step: ce high for exactly one rising edge, then a ce-low edge.
  task automatic step();
    @(negedge clk); ce = 1'b1;
    @(negedge clk); ce = 1'b0;
  endtask

  task automatic set_addr(input logic [23:0] byte_addr);
    addr = byte_addr[23:1];
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sel",   sel,        8'h00);
    chk("rst_dtack", dtack_n,    1'b1);
    chk("rst_vpa",   vpa_n,      1'b1);
    chk("rst_berr",  berr_n,     1'b1);
    chk("rst_ipl",   ipl_n,      3'b111);
    chk("rst_iackl", iack_level, 3'd0);
    reset = 1'b0;

    // Region 0, no wait states
    set_addr(24'h000100); fc = 3'b101; as_n = 1'b0;
    step();
    chk("r0_sel_wait",  sel,     8'h01);
    chk("r0_dtack_s0",  dtack_n, 1'b1);
    step();
    chk("r0_dtack_s1",  dtack_n, 1'b0);
    chk("r0_sel_ack",   sel,     8'h01);
    as_n = 1'b1;
    step();
    chk("r0_dtack_rel", dtack_n, 1'b1);
    chk("r0_sel_rel",   sel,     8'h00);

    // Region 3, two wait states
    set_addr(24'h018000); as_n = 1'b0; rw = 1'b0;
    step();
    chk("r3_sel",      sel,     8'h08);
    step();
    chk("r3_dtack_s1", dtack_n, 1'b1);
    step();
    chk("r3_dtack_s2", dtack_n, 1'b1);
    step();
    chk("r3_dtack_s3", dtack_n, 1'b0);
    as_n = 1'b1; rw = 1'b1;
    step();
    chk("r3_dtack_rel", dtack_n, 1'b1);

    // Region 2, external ready low for 10 steps
    set_addr(24'h010000); ext_rdy = 8'hFB; as_n = 1'b0;
    step();
    chk("r2_sel", sel, 8'h04);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("r2_dtack_wait", dtack_n, 1'b1);
    end
    ext_rdy = 8'hFF;
    step();
    chk("r2_dtack_s11", dtack_n, 1'b0);
    ext_rdy = 8'hFB;
    step();
    chk("r2_rdy_drop_ignored", dtack_n, 1'b0);
    as_n = 1'b1;
    step();
    chk("r2_dtack_rel", dtack_n, 1'b1);
    chk("r2_sel_rel",   sel,     8'h00);

    // Aborted cycle: as_n rises while still waiting
    as_n = 1'b0;
    step(); step(); step();
    as_n = 1'b1;
    step();
    chk("abort_sel",   sel,     8'h00);
    chk("abort_dtack", dtack_n, 1'b1);
    chk("abort_berr",  berr_n,  1'b1);

    // Ready stuck low
    as_n = 1'b0;
    step();
`ifdef M68K_BUS_BERR_EN
    for (int i = 0; i < 14; i++) begin
      step();
      chk("tmo_berr_wait", berr_n, 1'b1);
    end
    step();
    chk("tmo_berr_s15", berr_n,  1'b0);
    chk("tmo_dtack",    dtack_n, 1'b1);
    step();
    chk("tmo_berr_hold", berr_n, 1'b0);
    as_n = 1'b1;
    step();
    chk("tmo_berr_rel", berr_n, 1'b1);
    chk("tmo_sel_rel",  sel,    8'h00);
`else
    for (int i = 0; i < 20; i++) step();
    chk("stuck_berr",  berr_n,  1'b1);
    chk("stuck_dtack", dtack_n, 1'b1);
    chk("stuck_sel",   sel,     8'h04);
    as_n = 1'b1;
    step();
    chk("stuck_sel_rel", sel, 8'h00);
`endif
    ext_rdy = 8'hFF;

    // IPL encoder: one clk latency, independent of ce
    @(negedge clk); irq = 7'b0010100;
    @(negedge clk);
    chk("ipl_lvl5", ipl_n, 3'b010);
    irq = 7'b1000001;
    @(negedge clk);
    chk("ipl_lvl7", ipl_n, 3'b000);
    irq = 7'b0000001;
    @(negedge clk);
    chk("ipl_lvl1", ipl_n, 3'b110);
    irq = 7'b0010100;
    @(negedge clk);

    // Autovectored IACK at level 5
    fc = 3'b111; addr = {20'hFFFFF, 3'd5}; as_n = 1'b0;
    step();
    chk("iack_vpa",   vpa_n,      1'b0);
    chk("iack_level", iack_level, 3'd5);
    chk("iack_dtack", dtack_n,    1'b1);
    chk("iack_sel",   sel,        8'h00);
    as_n = 1'b1;
    step();
    chk("iack_vpa_rel", vpa_n, 1'b1);
    fc = 3'b101; irq = 7'd0;

    // Asynchronous reset in the middle of a wait
    set_addr(24'h010000); ext_rdy = 8'hFB; as_n = 1'b0;
    step();
    chk("rst_mid_sel_pre", sel, 8'h04);
    reset = 1'b1;
    #1;
    chk("rst_mid_sel",   sel,     8'h00);
    chk("rst_mid_dtack", dtack_n, 1'b1);
    as_n = 1'b1; ext_rdy = 8'hFF;
    @(negedge clk); reset = 1'b0;

    set_addr(24'h000100); as_n = 1'b0;
    step();
    chk("post_rst_sel", sel, 8'h01);
    step();
    chk("post_rst_dtack", dtack_n, 1'b0);
    as_n = 1'b1;
    step();
    chk("post_rst_rel", dtack_n, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
